bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single address-decoder master port between NUM_MASTERS requesters. It registers one winning request, drives it onto the decoder's valid/addr/wdata/we inputs and holds it until the decoder returns ready. It then routes ready/rdata/err back to the granted master only. It sits between the bus masters and addr_decoder.

---
 rtl/bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter sharing one address-decoder master port
//            between NUM_MASTERS requesters. One winning request is latched,
//            presented to the decoder and held until ready_i, then the
//            completion (ready/err/rdata) is routed back to the owner only.
// Option   : ARB_TIMEOUT_EN - forced error completion after TIMEOUT_CYCLES
//            BUSY cycles without a decoder response.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // master side
  input  logic [NUM_MASTERS-1:0]                 m_valid_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  output logic [NUM_MASTERS-1:0]                 m_ready_o,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  // decoder side
  output logic                                   valid_o,
  output logic [ADDR_WIDTH-1:0]                  addr_o,
  output logic [DATA_WIDTH-1:0]                  wdata_o,
  output logic                                   we_o,
  input  logic                                   ready_i,
  input  logic [DATA_WIDTH-1:0]                  rdata_i,
  input  logic                                   err_i
);

  localparam int                     IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;

  // arbitration bookkeeping
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        grant_idx;
  logic [NUM_MASTERS-1:0]  grant;

  // latched transaction
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;

  // round-robin search results
  int                      cand;
  logic [IDX_W-1:0]        cand_idx;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_found;

  // FSM decode
  logic                    busy;
  logic                    complete;
  logic                    err_bit;
  logic                    timeout_hit;

  // Rotating priority search: start one past the last owner and take the
  // first active requester, wrapping modulo NUM_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = int'(last_grant) + 1 + i;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      cand_idx = IDX_W'(cand);
      if (!win_found && m_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and completion decode; a completion is a decoder ready or a
  // forced timeout while BUSY.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (ready_i || timeout_hit) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the winning request on arbitration; release ownership on completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= LAST_IDX;
      grant_idx  <= '0;
      grant      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else if ((state == ST_IDLE) && win_found) begin
      grant_idx  <= win_idx;
      grant      <= ONE_HOT0 << win_idx;
      addr_q     <= m_addr_i[win_idx];
      wdata_q    <= m_wdata_i[win_idx];
      we_q       <= m_we_i[win_idx];
    end else if (complete) begin
      last_grant <= grant_idx;
      grant      <= '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;

  // Count BUSY cycles without a response; held at zero while IDLE so every
  // transaction starts from a cleared count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (!ready_i && (to_cnt != TIMEOUT_LAST)) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Uses the state register directly to keep this off the FSM decode path.
  assign timeout_hit = (state == ST_BUSY) && !ready_i && (to_cnt == TIMEOUT_LAST);
`else
  logic [7:0] unused_timeout_cfg;

  // Without the timeout option BUSY only ends on ready_i.
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

  // A decoder response reports its own error; a forced completion always errs.
  assign err_bit   = ready_i ? err_i : 1'b1;

  assign grant_o   = grant;
  assign valid_o   = busy;
  assign addr_o    = busy ? addr_q  : '0;
  assign wdata_o   = busy ? wdata_q : '0;
  assign we_o      = busy & we_q;

  assign m_ready_o = complete ? grant : '0;
  assign m_err_o   = (complete && err_bit) ? grant : '0;
  assign m_rdata_o = (complete && ready_i) ? rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Scoreboard bench for bus_arbiter. Stimulus pushes the expected
//            completion into a queue; a monitor pops and compares whenever
//            the arbiter pulses m_ready_o. Covers ARB_TIMEOUT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 14;
  localparam int DW = 8;

  typedef struct {
    logic [NM-1:0] ready;
    logic [NM-1:0] err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NM-1:0]         m_valid;
  logic [NM-1:0][AW-1:0] m_addr;
  logic [NM-1:0][DW-1:0] m_wdata;
  logic [NM-1:0]         m_we;
  logic [NM-1:0]         m_ready;
  logic [DW-1:0]         m_rdata;
  logic [NM-1:0]         m_err;
  logic [NM-1:0]         grant;
  logic                  valid;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         wdata;
  logic                  we;
  logic                  ready;
  logic [DW-1:0]         rdata;
  logic                  err;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS   (NM),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m_valid_i(m_valid),
    .m_addr_i (m_addr),
    .m_wdata_i(m_wdata),
    .m_we_i   (m_we),
    .m_ready_o(m_ready),
    .m_rdata_o(m_rdata),
    .m_err_o  (m_err),
    .grant_o  (grant),
    .valid_o  (valid),
    .addr_o   (addr),
    .wdata_o  (wdata),
    .we_o     (we),
    .ready_i  (ready),
    .rdata_i  (rdata),
    .err_i    (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_done(input logic [NM-1:0] r, input logic [NM-1:0] e,
                             input logic [DW-1:0] rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic w);
    exp_q.push_back('{ready: r, err: e, rdata: rd, addr: a, wdata: wd, we: w});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_valid = '0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    step();
    step();
    rst     = 1'b0;
  endtask

  // Monitor: every completion pulse must match the next expected entry.
  always @(negedge clk) begin
    if (m_ready !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ready: got m_ready_o=%b, expected no completion", m_ready);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_ready", 32'(m_ready), 32'(mon_e.ready));
        check("done_err",   32'(m_err),   32'(mon_e.err));
        check("done_rdata", 32'(m_rdata), 32'(mon_e.rdata));
        check("done_grant", 32'(grant),   32'(mon_e.ready));
        check("done_addr",  32'(addr),    32'(mon_e.addr));
        check("done_wdata", 32'(wdata),   32'(mon_e.wdata));
        check("done_we",    32'(we),      32'(mon_e.we));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before 100us");
    $fatal(1);
  end

  initial begin
    m_valid = '0; m_addr = '0; m_wdata = '0; m_we = '0;
    ready = 1'b0; err = 1'b0; rdata = '0;

    // Reset state
    sample();
    check("reset_grant",   32'(grant),   32'h0);
    check("reset_valid",   32'(valid),   32'h0);
    check("reset_m_ready", 32'(m_ready), 32'h0);
    check("reset_addr",    32'(addr),    32'h0);
    step();
    rst = 1'b0;

    // Master 0 write, ready on the 3rd BUSY cycle
    m_valid = 2'b01; m_addr[0] = 14'h1000; m_wdata[0] = 8'hA5; m_we = 2'b01;
    sample();
    check("t1_valid_before_edge", 32'(valid), 32'h0);
    step();
    sample();
    check("t1_valid",  32'(valid), 32'h1);
    check("t1_addr",   32'(addr),  32'h1000);
    check("t1_wdata",  32'(wdata), 32'hA5);
    check("t1_we",     32'(we),    32'h1);
    check("t1_grant",  32'(grant), 32'h1);
    step();
    sample();
    check("t1_addr_stable", 32'(addr),    32'h1000);
    check("t1_no_ready",    32'(m_ready), 32'h0);
    step();
    ready = 1'b1; rdata = 8'h00; err = 1'b0;
    expect_done(2'b01, 2'b00, 8'h00, 14'h1000, 8'hA5, 1'b1);
    sample();
    check("t1_valid_cycle3", 32'(valid), 32'h1);
    step();
    ready = 1'b0; m_valid = 2'b00;
    sample();
    check("t1_grant_after", 32'(grant), 32'h0);
    check("t1_valid_after", 32'(valid), 32'h0);

    // Both masters, continuous zero-wait: grants 0,1,0,1 in 2-cycle slots
    do_reset();
    m_valid = 2'b11;
    m_addr[0] = 14'h0100; m_wdata[0] = 8'h11; m_we[0] = 1'b1;
    m_addr[1] = 14'h0200; m_wdata[1] = 8'h22; m_we[1] = 1'b0;
    ready = 1'b1; rdata = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_done(2'b01, 2'b00, 8'h5A, 14'h0100, 8'h11, 1'b1);
      else            expect_done(2'b10, 2'b00, 8'h5A, 14'h0200, 8'h22, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      sample();
      check("rr_valid", 32'(valid), 32'h1);
      check("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      if (k == 3) begin
        m_valid = 2'b00; ready = 1'b0;
      end
      sample();
      check("rr_idle_valid", 32'(valid), 32'h0);
      check("rr_idle_grant", 32'(grant), 32'h0);
    end

    // Master 1 read 0x2800, immediate error response
    step();
    m_valid = 2'b10; m_addr[1] = 14'h2800; m_wdata[1] = 8'h00; m_we = 2'b00;
    ready = 1'b1; err = 1'b1; rdata = 8'h00;
    expect_done(2'b10, 2'b10, 8'h00, 14'h2800, 8'h00, 1'b0);
    step();
    sample();
    check("err_grant", 32'(grant), 32'h2);
    step();
    m_valid = 2'b00; ready = 1'b0; err = 1'b0;
    sample();
    check("err_idle_valid", 32'(valid), 32'h0);
    check("err_idle_grant", 32'(grant), 32'h0);

    // Master 1 read 0x2100, reset mid-BUSY, then master 0 wins first
    step();
    m_valid = 2'b10; m_addr[1] = 14'h2100; rdata = 8'hEF; ready = 1'b0;
    step();
    sample();
    check("rst_busy_valid", 32'(valid), 32'h1);
    step();
    rst = 1'b1; ready = 1'b1;
    #1;
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_m_ready", 32'(m_ready), 32'h0);
    check("rst_m_err",   32'(m_err),   32'h0);
    check("rst_m_rdata", 32'(m_rdata), 32'h0);
    check("rst_addr",    32'(addr),    32'h0);
    check("rst_wdata",   32'(wdata),   32'h0);
    check("rst_we",      32'(we),      32'h0);
    step();
    rst = 1'b0; ready = 1'b0;
    m_valid = 2'b11; m_addr[0] = 14'h0300; m_wdata[0] = 8'h3C; m_we = 2'b01;
    step();
    ready = 1'b1; rdata = 8'h00;
    expect_done(2'b01, 2'b00, 8'h00, 14'h0300, 8'h3C, 1'b1);
    sample();
    check("post_rst_grant_m0", 32'(grant), 32'h1);
    step();
    m_valid = 2'b10; ready = 1'b0;
    sample();
    check("post_rst_idle", 32'(grant), 32'h0);
    step();
    ready = 1'b1; rdata = 8'hEF;
    expect_done(2'b10, 2'b00, 8'hEF, 14'h2100, 8'h00, 1'b0);
    sample();
    check("post_rst_grant_m1", 32'(grant), 32'h2);
    step();
    m_valid = 2'b00; ready = 1'b0; rdata = 8'h00;
    sample();
    check("post_rst_final_valid", 32'(valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
    // No decoder response: forced error completion on the 16th BUSY cycle
    step();
    m_valid = 2'b01; m_addr[0] = 14'h0444; m_wdata[0] = 8'h44; m_we = 2'b00;
    ready = 1'b0; rdata = 8'h99;
    expect_done(2'b01, 2'b01, 8'h00, 14'h0444, 8'h44, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      step();
      sample();
      check("to_valid",   32'(valid),   32'h1);
      check("to_m_ready", 32'(m_ready), (c == 16) ? 32'h1 : 32'h0);
    end
    step();
    m_valid = 2'b00;
    sample();
    check("to_valid_dropped", 32'(valid), 32'h0);
    rdata = 8'h00;
`endif

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
